// File: rtl/n_term_cfg_tile.sv
// -----------------------------------------------------------------------------
// n_term_cfg_tile
//   North-edge termination tile with configurable termination modes. Each of
//   the five N-bound wire groups is looped back onto its S-bound partner using
//   one of four modes held in a 10-bit mode register loaded from the
//   configuration frame column:
//     00 combinational loopback (the power-up behaviour)
//     01 registered loopback (one UserCLK of latency)
//     10 tie-0
//     11 walking-one routing test pattern
//   Group widths must be at least 2 (the rotate slices assume it).
//
// Ports
//   UserCLK        fabric user clock, clocks all state here
//   RESETn         asynchronous reset, active low
//   N1END          group 0 input  (W1)  -> S1BEG  group 0 output
//   N2MID          group 1 input  (W2)  -> S2BEG  group 1 output
//   N2END          group 2 input  (W2)  -> S2BEGb group 2 output
//   N4END          group 3 input  (W4)  -> S4BEG  group 3 output
//   NN4END         group 4 input  (W4)  -> SS4BEG group 4 output
//   FrameData      configuration data row; bits [9:0] carry the modes
//   FrameStrobe    column frame strobes; bit CFG_FRAME loads the modes
//   FrameStrobe_O  buffered FrameStrobe for the next tile
//   UserCLKo       buffered UserCLK for the next tile
// -----------------------------------------------------------------------------
module n_term_cfg_tile #(
  parameter int W1              = 4,
  parameter int W2              = 8,
  parameter int W4              = 16,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int CFG_FRAME       = 0
) (
  input  logic                       UserCLK,
  input  logic                       RESETn,
  input  logic [W1-1:0]              N1END,
  input  logic [W2-1:0]              N2MID,
  input  logic [W2-1:0]              N2END,
  input  logic [W4-1:0]              N4END,
  input  logic [W4-1:0]              NN4END,
  output logic [W1-1:0]              S1BEG,
  output logic [W2-1:0]              S2BEG,
  output logic [W2-1:0]              S2BEGb,
  output logic [W4-1:0]              S4BEG,
  output logic [W4-1:0]              SS4BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       UserCLKo
);

  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_REG  = 2'b01;
  localparam logic [1:0] MODE_TIE0 = 2'b10;
  localparam logic [1:0] MODE_WALK = 2'b11;

  localparam logic [W1-1:0] ONE_W1 = {{(W1-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0] ONE_W2 = {{(W2-1){1'b0}}, 1'b1};
  localparam logic [W4-1:0] ONE_W4 = {{(W4-1){1'b0}}, 1'b1};

  logic [9:0]    cfg_r;
  logic [1:0]    mode0_s, mode1_s, mode2_s, mode3_s, mode4_s;

  logic [W1-1:0] d1_r;
  logic [W2-1:0] d2_r, d2b_r;
  logic [W4-1:0] d4_r, dd4_r;

  logic [W1-1:0] w1_r;
  logic [W2-1:0] w2_r, w2b_r;
  logic [W4-1:0] w4_r, dw4_r;

  assign mode0_s = cfg_r[1:0];
  assign mode1_s = cfg_r[3:2];
  assign mode2_s = cfg_r[5:4];
  assign mode3_s = cfg_r[7:6];
  assign mode4_s = cfg_r[9:8];

  // Only FrameData[9:0] is meaningful here; fold the rest into a sink.
  generate
    if (FrameBitsPerRow > 10) begin : g_frame_sink
      logic unused_frame_bits_s;
      assign unused_frame_bits_s = ^FrameData[FrameBitsPerRow-1:10];
    end
  endgenerate

  // Mode register: reloads on every edge the config strobe is high.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      cfg_r <= 10'd0;
    end else if (FrameStrobe[CFG_FRAME]) begin
      cfg_r <= FrameData[9:0];
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // Delay registers sample unconditionally so entering mode 01 has no bubble.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      d1_r  <= {W1{1'b0}};
      d2_r  <= {W2{1'b0}};
      d2b_r <= {W2{1'b0}};
      d4_r  <= {W4{1'b0}};
      dd4_r <= {W4{1'b0}};
    end else begin
      d1_r  <= N1END;
      d2_r  <= N2MID;
      d2b_r <= N2END;
      d4_r  <= N4END;
      dd4_r <= NN4END;
    end
  end

  // Walking-one registers: rotate while the mode held before this edge is 11,
  // otherwise park at 1 so that entering the mode always starts from bit 0.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      w1_r  <= ONE_W1;
      w2_r  <= ONE_W2;
      w2b_r <= ONE_W2;
      w4_r  <= ONE_W4;
      dw4_r <= ONE_W4;
    end else begin
      w1_r  <= (mode0_s == MODE_WALK) ? {w1_r[W1-2:0],  w1_r[W1-1]}  : ONE_W1;
      w2_r  <= (mode1_s == MODE_WALK) ? {w2_r[W2-2:0],  w2_r[W2-1]}  : ONE_W2;
      w2b_r <= (mode2_s == MODE_WALK) ? {w2b_r[W2-2:0], w2b_r[W2-1]} : ONE_W2;
      w4_r  <= (mode3_s == MODE_WALK) ? {w4_r[W4-2:0],  w4_r[W4-1]}  : ONE_W4;
      dw4_r <= (mode4_s == MODE_WALK) ? {dw4_r[W4-2:0], dw4_r[W4-1]} : ONE_W4;
    end
  end

  // Output select for groups 0..2; cfg_r is 0 in reset so outputs are comb loopback.
  always_comb begin
    S1BEG = N1END;
    case (mode0_s)
      MODE_COMB: S1BEG = N1END;
      MODE_REG:  S1BEG = d1_r;
      MODE_TIE0: S1BEG = {W1{1'b0}};
      MODE_WALK: S1BEG = w1_r;
      default:   S1BEG = N1END;
    endcase

    S2BEG = N2MID;
    case (mode1_s)
      MODE_COMB: S2BEG = N2MID;
      MODE_REG:  S2BEG = d2_r;
      MODE_TIE0: S2BEG = {W2{1'b0}};
      MODE_WALK: S2BEG = w2_r;
      default:   S2BEG = N2MID;
    endcase

    S2BEGb = N2END;
    case (mode2_s)
      MODE_COMB: S2BEGb = N2END;
      MODE_REG:  S2BEGb = d2b_r;
      MODE_TIE0: S2BEGb = {W2{1'b0}};
      MODE_WALK: S2BEGb = w2b_r;
      default:   S2BEGb = N2END;
    endcase
  end

  // Output select for groups 3..4.
  always_comb begin
    S4BEG = N4END;
    case (mode3_s)
      MODE_COMB: S4BEG = N4END;
      MODE_REG:  S4BEG = d4_r;
      MODE_TIE0: S4BEG = {W4{1'b0}};
      MODE_WALK: S4BEG = w4_r;
      default:   S4BEG = N4END;
    endcase

    SS4BEG = NN4END;
    case (mode4_s)
      MODE_COMB: SS4BEG = NN4END;
      MODE_REG:  SS4BEG = dd4_r;
      MODE_TIE0: SS4BEG = {W4{1'b0}};
      MODE_WALK: SS4BEG = dw4_r;
      default:   SS4BEG = NN4END;
    endcase
  end

  // Pass-through buffers for the column chain.
  assign FrameStrobe_O = FrameStrobe;
  assign UserCLKo      = UserCLK;

endmodule

// File: tb/tb_n_term_cfg_tile.sv
module tb_n_term_cfg_tile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  n1;
  logic [7:0]  n2m, n2e;
  logic [15:0] n4, nn4;
  logic [3:0]  s1;
  logic [7:0]  s2, s2b;
  logic [15:0] s4, ss4;
  logic [31:0] frame_data;
  logic [19:0] frame_strobe, frame_strobe_o;
  logic        clk_o;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG} or a single field.
  logic [51:0] sb_q[$];
  logic [51:0] exp_v;
  logic [51:0] act_v;

  always #5 clk = ~clk;

  n_term_cfg_tile dut (
    .UserCLK(clk), .RESETn(rst_n),
    .N1END(n1), .N2MID(n2m), .N2END(n2e), .N4END(n4), .NN4END(nn4),
    .S1BEG(s1), .S2BEG(s2), .S2BEGb(s2b), .S4BEG(s4), .SS4BEG(ss4),
    .FrameData(frame_data), .FrameStrobe(frame_strobe),
    .FrameStrobe_O(frame_strobe_o), .UserCLKo(clk_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [9:0] v);
    frame_data   = {22'd0, v};
    frame_strobe = 20'h00001;
    tick();
    frame_strobe = 20'h00000;
    frame_data   = 32'd0;
  endtask

  task automatic drive_random;
    n1  = 4'($urandom);
    n2m = 8'($urandom);
    n2e = 8'($urandom);
    n4  = 16'($urandom);
    nn4 = 16'($urandom);
    sb_q.push_back({n1, n2m, n2e, n4, nn4});
  endtask

  task automatic test_reset;
    // In reset: everything loops back combinationally, including N2END=A5.
    n1 = 4'h3; n2m = 8'h5C; n2e = 8'hA5; n4 = 16'h1234; nn4 = 16'hBEEF;
    sb_q.push_back({4'h3, 8'h5C, 8'hA5, 16'h1234, 16'hBEEF});
    #1;
    exp_v = sb_q.pop_front();
    act_v = {s1, s2, s2b, s4, ss4};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL reset_loopback got %h expected %h", act_v, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive_random();
      #1;
      exp_v = sb_q.pop_front();
      act_v = {s1, s2, s2b, s4, ss4};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_loopback_rand got %h expected %h", act_v, exp_v);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_random();
      #1;
      exp_v = sb_q.pop_front();
      act_v = {s1, s2, s2b, s4, ss4};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL post_reset_loopback got %h expected %h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_registered;
    n2m = 8'h00;
    sb_q.push_back(52'(8'h00));
    load_cfg(10'h004);
    n2m = 8'h11;
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (s2 !== exp_v[7:0]) begin
      errors++;
      $display("FAIL reg_enter got %h expected %h", s2, exp_v[7:0]);
    end
    n1 = 4'h9;
    sb_q.push_back(52'(4'h9));
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (s1 !== exp_v[3:0]) begin
      errors++;
      $display("FAIL reg_s1_comb got %h expected %h", s1, exp_v[3:0]);
    end
    sb_q.push_back(52'(8'h11));
    tick();
    n2m = 8'h22;
    sb_q.push_back(52'(8'h22));
    exp_v = sb_q.pop_front();
    checks++;
    if (s2 !== exp_v[7:0]) begin
      errors++;
      $display("FAIL reg_first got %h expected %h", s2, exp_v[7:0]);
    end
    tick();
    n2m = 8'h33;
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (s2 !== exp_v[7:0]) begin
      errors++;
      $display("FAIL reg_second got %h expected %h", s2, exp_v[7:0]);
    end
  endtask

  task automatic test_walk_group3;
    logic [15:0] w;
    load_cfg(10'h0C0);
    for (int i = 0; i < 17; i++) begin
      w = 16'h0001 << (i % 16);
      sb_q.push_back(52'(w));
      exp_v = sb_q.pop_front();
      checks++;
      if (s4 !== exp_v[15:0]) begin
        errors++;
        $display("FAIL walk4 step %0d got %h expected %h", i, s4, exp_v[15:0]);
      end
      if (i < 16) tick();
    end
    load_cfg(10'h080);
    sb_q.push_back(52'(16'h0000));
    exp_v = sb_q.pop_front();
    checks++;
    if (s4 !== exp_v[15:0]) begin
      errors++;
      $display("FAIL walk4_tie0 got %h expected %h", s4, exp_v[15:0]);
    end
    tick();
    load_cfg(10'h0C0);
    sb_q.push_back(52'(16'h0001));
    exp_v = sb_q.pop_front();
    checks++;
    if (s4 !== exp_v[15:0]) begin
      errors++;
      $display("FAIL walk4_restart got %h expected %h", s4, exp_v[15:0]);
    end
    tick();
    sb_q.push_back(52'(16'h0002));
    exp_v = sb_q.pop_front();
    checks++;
    if (s4 !== exp_v[15:0]) begin
      errors++;
      $display("FAIL walk4_restart2 got %h expected %h", s4, exp_v[15:0]);
    end
  endtask

  task automatic test_walk_all;
    logic [3:0]  e1;
    logic [7:0]  e2;
    logic [15:0] e4;
    load_cfg(10'h000);
    load_cfg(10'h3FF);
    for (int i = 0; i < 17; i++) begin
      e1 = 4'h1 << (i % 4);
      e2 = 8'h01 << (i % 8);
      e4 = 16'h0001 << (i % 16);
      sb_q.push_back({e1, e2, e2, e4, e4});
      exp_v = sb_q.pop_front();
      act_v = {s1, s2, s2b, s4, ss4};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL walk_all step %0d got %h expected %h", i, act_v, exp_v);
      end
      tick();
    end
    // Asynchronous reset mid-sequence, away from any clock edge.
    drive_random();
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = sb_q.pop_front();
    act_v = {s1, s2, s2b, s4, ss4};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", act_v, exp_v);
    end
    tick();
    drive_random();
    #1;
    exp_v = sb_q.pop_front();
    act_v = {s1, s2, s2b, s4, ss4};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL in_reset_edge got %h expected %h", act_v, exp_v);
    end
    rst_n = 1'b1;
    tick();
    drive_random();
    #1;
    exp_v = sb_q.pop_front();
    act_v = {s1, s2, s2b, s4, ss4};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL after_release got %h expected %h", act_v, exp_v);
    end
  endtask

  task automatic test_strobe;
    frame_strobe = 20'h5A5A4;
    for (int i = 0; i < 4; i++) begin
      frame_data = $urandom | 32'h000003FF;
      tick();
      drive_random();
      #1;
      exp_v = sb_q.pop_front();
      act_v = {s1, s2, s2b, s4, ss4};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL strobe_off_cfg got %h expected %h", act_v, exp_v);
      end
    end
    frame_data   = 32'd0;
    frame_strobe = 20'h5A5A5;
    sb_q.push_back(52'(20'h5A5A5));
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (frame_strobe_o !== exp_v[19:0]) begin
      errors++;
      $display("FAIL strobe_buf got %h expected %h", frame_strobe_o, exp_v[19:0]);
    end
    tick();
    frame_strobe = 20'h00000;
    checks++;
    if (clk_o !== 1'b1) begin
      errors++;
      $display("FAIL clk_buf_high got %b expected 1", clk_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (clk_o !== 1'b0) begin
      errors++;
      $display("FAIL clk_buf_low got %b expected 0", clk_o);
    end
  endtask

  task automatic test_back_to_back;
    // Strobe held for two edges: the second value (group1=01) wins.
    frame_strobe = 20'h00001;
    frame_data   = 32'h000000C0;
    tick();
    frame_data   = 32'h00000004;
    n2m          = 8'h66;
    sb_q.push_back(52'(8'h66));
    tick();
    frame_strobe = 20'h00000;
    n2m          = 8'h77;
    n4           = 16'hC3C3;
    sb_q.push_back(52'(16'hC3C3));
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (s2 !== exp_v[7:0]) begin
      errors++;
      $display("FAIL b2b_reg got %h expected %h", s2, exp_v[7:0]);
    end
    exp_v = sb_q.pop_front();
    checks++;
    if (s4 !== exp_v[15:0]) begin
      errors++;
      $display("FAIL b2b_last_wins got %h expected %h", s4, exp_v[15:0]);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    n1           = 4'h0;
    n2m          = 8'h00;
    n2e          = 8'h00;
    n4           = 16'h0000;
    nn4          = 16'h0000;
    frame_data   = 32'd0;
    frame_strobe = 20'd0;
    test_reset();
    test_registered();
    test_walk_group3();
    test_walk_all();
    test_strobe();
    test_back_to_back();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
